// File: rtl/mram_wbuf_pkg.sv
// mram_wbuf_pkg: widths and the buffer entry type for the SRAM write buffer.
package mram_wbuf_pkg;
    localparam int P_DW  = 6;
    localparam int AW    = 6;
    localparam int P_DEP = 2;
    localparam int DW    = 1 << P_DW;
    localparam int NB    = DW / 8;
    localparam int DEP   = 1 << P_DEP;

    typedef struct packed {
        logic          vld;
        logic [AW-1:0] addr;
        logic [NB-1:0] be;
        logic [DW-1:0] dat;
    } entry_t;

    function automatic logic [DW-1:0] byte_merge(input logic [DW-1:0] old_dat,
                                                 input logic [DW-1:0] new_dat,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = old_dat;
        for (int b = 0; b < NB; b++) r[8*b +: 8] = be[b] ? new_dat[8*b +: 8] : r[8*b +: 8];
        return r;
    endfunction
endpackage

// File: rtl/mram_wbuf_fwd.sv
// mram_wbuf_fwd: byte-wise forward merge of all buffered entries matching an address.
module mram_wbuf_fwd
    import mram_wbuf_pkg::*;
(
    input  entry_t [DEP-1:0]  ent,
    input  logic [P_DEP-1:0]  head,
    input  logic [AW-1:0]     addr,
    output logic [NB-1:0]     fwd_be,
    output logic [DW-1:0]     fwd_dat
);
    entry_t e;

    // Walk oldest to youngest so later entries overwrite earlier bytes.
    always_comb begin
        fwd_be  = '0;
        fwd_dat = '0;
        e       = ent[head];
        for (int k = 0; k < DEP; k++) begin
            e = ent[head + P_DEP'(k)];
            if (e.vld && e.addr == addr) begin
                fwd_dat = byte_merge(fwd_dat, e.dat, e.be);
                fwd_be  = fwd_be | e.be;
            end
        end
    end
endmodule

// File: rtl/mram_wbuf_sp.sv
// mram_wbuf_sp: coalescing write buffer and read/drain arbiter for a single-port
// byte-enable SRAM, with store-to-load forwarding into read data.
module mram_wbuf_sp
    import mram_wbuf_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          RREQ_VLD,
    output logic          RREQ_RDY,
    input  logic [AW-1:0] RREQ_ADDR,
    output logic          RRESP_VLD,
    output logic [DW-1:0] RRESP_DAT,
    input  logic          WREQ_VLD,
    output logic          WREQ_RDY,
    input  logic [AW-1:0] WREQ_ADDR,
    input  logic [NB-1:0] WREQ_BE,
    input  logic [DW-1:0] WREQ_DAT,
    output logic          EMPTY,
    output logic [AW-1:0] RAM_ADDR,
    output logic          RAM_RE,
    output logic [NB-1:0] RAM_WE,
    output logic [DW-1:0] RAM_DIN,
    input  logic [DW-1:0] RAM_DOUT
);
    entry_t [DEP-1:0] ent_q, ent_d;
    logic [P_DEP-1:0] head_q, head_d, tail_q, tail_d, slot, mi;
    logic [P_DEP:0]   cnt_q, cnt_d;
    logic [NB-1:0]    fwd_be_q, fwd_be_d;
    logic [DW-1:0]    fwd_dat_q, fwd_dat_d;
    logic             rresp_vld_q, rresp_vld_d;
    logic             pop, match, wfire, push;
    entry_t           head_e;

    mram_wbuf_fwd u_fwd (
        .ent     (ent_q),
        .head    (head_q),
        .addr    (RREQ_ADDR),
        .fwd_be  (fwd_be_d),
        .fwd_dat (fwd_dat_d)
    );

    always_comb begin
        head_e = ent_q[head_q];
        pop    = !RST && !RREQ_VLD && cnt_q != '0;
        match  = 1'b0;
        mi     = '0;
        slot   = head_q;
        // The head being drained this cycle cannot absorb a merge.
        for (int k = 0; k < DEP; k++) begin
            slot = head_q + P_DEP'(k);
            if (ent_q[slot].vld && ent_q[slot].addr == WREQ_ADDR && !(pop && k == 0)) begin
                match = 1'b1;
                mi    = slot;
            end
        end
        WREQ_RDY = cnt_q < (P_DEP+1)'(DEP) || match || pop;
        wfire    = !RST && WREQ_VLD && WREQ_RDY && |WREQ_BE;
        push     = wfire && !match;
        ent_d    = ent_q;
        if (pop) ent_d[head_q].vld = 1'b0;
        if (wfire && match) begin
            ent_d[mi].be  = ent_q[mi].be | WREQ_BE;
            ent_d[mi].dat = byte_merge(ent_q[mi].dat, WREQ_DAT, WREQ_BE);
        end
        if (push) ent_d[tail_q] = {1'b1, WREQ_ADDR, WREQ_BE, WREQ_DAT};
        head_d      = head_q + P_DEP'(pop);
        tail_d      = tail_q + P_DEP'(push);
        cnt_d       = cnt_q + (P_DEP+1)'(push) - (P_DEP+1)'(pop);
        rresp_vld_d = RREQ_VLD;
        RREQ_RDY    = 1'b1;
        RAM_RE      = RREQ_VLD && !RST;
        RAM_ADDR    = RREQ_VLD ? RREQ_ADDR : head_e.addr;
        RAM_WE      = pop ? head_e.be : '0;
        RAM_DIN     = head_e.dat;
        RRESP_VLD   = rresp_vld_q;
        RRESP_DAT   = rresp_vld_q ? byte_merge(RAM_DOUT, fwd_dat_q, fwd_be_q) : '0;
        EMPTY       = cnt_q == '0;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            ent_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            cnt_q       <= '0;
            fwd_be_q    <= '0;
            fwd_dat_q   <= '0;
            rresp_vld_q <= 1'b0;
        end else begin
            ent_q       <= ent_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            cnt_q       <= cnt_d;
            fwd_be_q    <= fwd_be_d;
            fwd_dat_q   <= fwd_dat_d;
            rresp_vld_q <= rresp_vld_d;
        end
    end
endmodule

// File: tb/tb_mram_wbuf_sp.sv
// tb_mram_wbuf_sp: randomized and directed scoreboard bench; the reference model is the
// architectural memory image every read must observe.
module tb_mram_wbuf_sp;
    localparam int AW  = 6;
    localparam int DW  = 64;
    localparam int NB  = 8;
    localparam int DEP = 4;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          RREQ_VLD = 1'b0, RREQ_RDY;
    logic [AW-1:0] RREQ_ADDR = '0;
    logic          RRESP_VLD;
    logic [DW-1:0] RRESP_DAT;
    logic          WREQ_VLD = 1'b0, WREQ_RDY;
    logic [AW-1:0] WREQ_ADDR = '0;
    logic [NB-1:0] WREQ_BE = '0;
    logic [DW-1:0] WREQ_DAT = '0;
    logic          EMPTY;
    logic [AW-1:0] RAM_ADDR;
    logic          RAM_RE;
    logic [NB-1:0] RAM_WE;
    logic [DW-1:0] RAM_DIN;
    logic [DW-1:0] RAM_DOUT = '0;

    logic [DW-1:0] sram [1<<AW];
    logic [DW-1:0] arch [1<<AW];
    logic [DW-1:0] sav  [3];
    logic [DW-1:0] exp_q [$];
    logic          sram_init = 1'b0;
    int            pass_cnt = 0, chk_cnt = 0;

    always #5 clk = ~clk;

    mram_wbuf_sp dut (
        .CLK(clk), .RST(RST),
        .RREQ_VLD(RREQ_VLD), .RREQ_RDY(RREQ_RDY), .RREQ_ADDR(RREQ_ADDR),
        .RRESP_VLD(RRESP_VLD), .RRESP_DAT(RRESP_DAT),
        .WREQ_VLD(WREQ_VLD), .WREQ_RDY(WREQ_RDY), .WREQ_ADDR(WREQ_ADDR),
        .WREQ_BE(WREQ_BE), .WREQ_DAT(WREQ_DAT), .EMPTY(EMPTY),
        .RAM_ADDR(RAM_ADDR), .RAM_RE(RAM_RE), .RAM_WE(RAM_WE),
        .RAM_DIN(RAM_DIN), .RAM_DOUT(RAM_DOUT)
    );

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Behavioural SRAM, 1-cycle read latency; contents seeded once at time 0.
    always @(posedge clk) begin
        if (!sram_init) begin
            for (int i = 0; i < (1 << AW); i++) sram[i] = {$urandom, $urandom};
            sram[5] = 64'h0123456789ABCDEF;
            sram_init = 1'b1;
        end
        if (RAM_RE) RAM_DOUT <= sram[RAM_ADDR];
        for (int b = 0; b < NB; b++)
            if (RAM_WE[b]) sram[RAM_ADDR][8*b +: 8] = RAM_DIN[8*b +: 8];
    end

    // Monitor/scoreboard: check last cycle's read, then record this cycle's requests.
    always @(negedge clk) begin
        if (RST) exp_q.delete();
        else begin
            if (exp_q.size() != 0) begin
                chk("rresp_vld", {63'd0, RRESP_VLD}, 64'd1);
                chk("rresp_dat", RRESP_DAT, exp_q.pop_front());
            end else if (RRESP_VLD) chk("rresp_spurious", {63'd0, RRESP_VLD}, 64'd0);
            if (RREQ_VLD) exp_q.push_back(arch[RREQ_ADDR]);
            if (WREQ_VLD && WREQ_RDY)
                for (int b = 0; b < NB; b++)
                    if (WREQ_BE[b]) arch[WREQ_ADDR][8*b +: 8] = WREQ_DAT[8*b +: 8];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rv, input logic [AW-1:0] ra, input logic wv,
                         input logic [AW-1:0] wa, input logic [NB-1:0] be, input logic [DW-1:0] wd);
        RREQ_VLD = rv; RREQ_ADDR = ra;
        WREQ_VLD = wv; WREQ_ADDR = wa; WREQ_BE = be; WREQ_DAT = wd;
    endtask

    task automatic idle();
        drive(1'b0, '0, 1'b0, '0, '0, '0);
    endtask

    task automatic do_reset();
        RST = 1'b1;
        idle();
        repeat (2) tick();
        for (int i = 0; i < (1 << AW); i++) arch[i] = sram[i];
        @(negedge clk);
        chk("rst_rreq_rdy", {63'd0, RREQ_RDY}, 64'd1);
        chk("rst_rresp_vld", {63'd0, RRESP_VLD}, 64'd0);
        chk("rst_rresp_dat", RRESP_DAT, 64'd0);
        chk("rst_wreq_rdy", {63'd0, WREQ_RDY}, 64'd1);
        chk("rst_empty", {63'd0, EMPTY}, 64'd1);
        chk("rst_ram_re", {63'd0, RAM_RE}, 64'd0);
        chk("rst_ram_we", {56'd0, RAM_WE}, 64'd0);
        tick();
        RST = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        idle();
        while (!EMPTY && n < 64) begin
            tick();
            n++;
        end
        chk("drain_empty", {63'd0, EMPTY}, 64'd1);
    endtask

    initial begin
        do_reset();
        // Same-cycle read sees old memory; next read sees forwarded write.
        drive(1, 3, 1, 3, 8'hFF, 64'h1111111111111111);
        tick();
        drive(1, 3, 0, 0, 0, 0);
        tick();
        idle();
        @(negedge clk);
        chk("fwd_full", RRESP_DAT, 64'h1111111111111111);
        tick();
        // Partial forward over SRAM contents.
        drain();
        drive(1, 60, 1, 5, 8'h0F, 64'h00000000AABBCCDD);
        tick();
        drive(1, 5, 0, 0, 0, 0);
        tick();
        idle();
        @(negedge clk);
        chk("fwd_partial", RRESP_DAT, 64'h01234567AABBCCDD);
        tick();
        // Coalesce two writes into one entry.
        drain();
        drive(1, 60, 1, 7, 8'h01, 64'h11);
        tick();
        drive(1, 60, 1, 7, 8'h02, 64'h2200);
        tick();
        idle();
        @(negedge clk);
        chk("coal_we", {56'd0, RAM_WE}, 64'h03);
        chk("coal_addr", {58'd0, RAM_ADDR}, 64'd7);
        chk("coal_din", {48'd0, RAM_DIN[15:0]}, 64'h2211);
        chk("coal_not_empty", {63'd0, EMPTY}, 64'd0);
        tick();
        chk("coal_single", {63'd0, EMPTY}, 64'd1);
        // Full buffer, then simultaneous pop and push.
        drain();
        for (int k = 0; k <= DEP; k++) begin
            drive(1, 60, 1, 6'(10 + k), 8'hFF, {$urandom, $urandom});
            @(negedge clk);
            chk("full_rdy", {63'd0, WREQ_RDY}, {63'd0, k < DEP});
            tick();
        end
        RREQ_VLD = 1'b0;
        @(negedge clk);
        chk("pushpop_rdy", {63'd0, WREQ_RDY}, 64'd1);
        chk("pushpop_we", {56'd0, RAM_WE}, 64'hFF);
        tick();
        drive(1, 60, 1, 20, 8'hFF, 64'h5);
        @(negedge clk);
        chk("still_full", {63'd0, WREQ_RDY}, 64'd0);
        tick();
        // Drain order and pointer wrap with idle gaps.
        drain();
        for (int k = 0; k < 3 * DEP; k++) begin
            drive(0, 0, 1, 6'(30 + k), 8'($urandom), {$urandom, $urandom});
            tick();
            idle();
            tick();
        end
        drain();
        // Randomized traffic over a small address window to force merges and forwarding.
        for (int n = 0; n < 400; n++) begin
            drive($urandom_range(0, 2) == 0, 6'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
                  {$urandom, $urandom});
            tick();
        end
        drain();
        tick();
        for (int i = 0; i < (1 << AW); i++) chk($sformatf("sram_%0d", i), sram[i], arch[i]);
        // Reset mid-operation discards buffered writes and the in-flight read.
        for (int i = 0; i < 3; i++) sav[i] = sram[40 + i];
        for (int i = 0; i < 3; i++) begin
            drive(1, 60, 1, 6'(40 + i), 8'hFF, {$urandom, $urandom});
            tick();
        end
        do_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("post_rst_we", {56'd0, RAM_WE}, 64'd0);
            chk("post_rst_empty", {63'd0, EMPTY}, 64'd1);
            tick();
        end
        for (int i = 0; i < 3; i++) chk("rst_discard", sram[40 + i], sav[i]);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
